cpu_bus_responder: RTL and testbench
====================================

// Module: cpu_bus_responder
// PURPOSE
//  Slave end of the 6502 core bus (address/out/we driven by the core; in/hold driven here).
//  Decodes each CPU access to an external 8-bit async SRAM or a 4-register I/O page (LEDs, keys).
//  Inserts wait states by holding `hold` low until data is ready. Sits between core and board pins.
// PARAMETERS
//  ADDR_W       15        SRAM address width; non-I/O CPU addresses alias onto address[ADDR_W-1:0]
//  WAIT_STATES  2         extra SRAM cycles per access (0..15)
//  IO_BASE      16'hBF00  base of I/O page; I/O hit when address[15:2] == IO_BASE[15:2]
// PORTS
//  clock       in   1       system clock, all state on rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  address     in   16      CPU address, stable from request cycle until hold=1 cycle
//  out         in   8       CPU write data
//  we          in   1       CPU write strobe (1 = write)
//  in          out  8       read data to CPU, registered
//  hold        out  1       1 = access completes this cycle, CPU advances; 0 = stall
//  sram_addr   out  ADDR_W  SRAM address
//  sram_d_o    out  8       SRAM write data
//  sram_d_oe   out  1       drive SRAM data pins
//  sram_d_i    in   8       SRAM read data
//  sram_oe_n   out  1       SRAM output enable, active low
//  sram_we_n   out  1       SRAM write enable, active low
//  key         in   4       raw buttons, asynchronous
//  led         out  8       LED register
// BEHAVIOUR
//  Reset values: in=0, hold=0, led=0, sram_oe_n=1, sram_we_n=1, sram_d_oe=0, sram_addr=0, edge latch=0, state=S_REQ.
//  FSM (one access per pass, no pipelining):
//   S_REQ : latch address/out/we; drive sram_addr, sram_d_o; hold=0.
//           I/O hit -> S_DONE. SRAM with WAIT_STATES=0 -> S_DONE. Otherwise -> S_WAIT with cnt=WAIT_STATES-1.
//   S_WAIT: hold=0; decrement cnt; at cnt==0 -> S_DONE.
//   S_DONE: hold=1 for exactly one cycle -> S_REQ.
//  Latency: SRAM access = 2+WAIT_STATES cycles; I/O access = 2 cycles.
//  SRAM read: sram_oe_n=0 from S_REQ through S_DONE. sram_d_i captured into `in` at the last edge before S_DONE,
//   so `in` is valid throughout the hold=1 cycle and held until the next capture.
//  SRAM write: sram_d_oe=1 in S_REQ..S_DONE. sram_we_n=0 in S_REQ and S_WAIT, 1 in S_DONE (data held one cycle past we rise).
//   sram_oe_n and sram_we_n are never low together.
//  I/O page (offset = address[1:0]): captured/written at the S_REQ->S_DONE edge.
//   0 LED    R/W  read returns led
//   1 KEY    R    {4'b0, key_sync}; key passes through 2-flop synchroniser
//   2 EDGE   R/W1C {4'b0, edge}; rising edge of key_sync sets bit; write-1 clears;
//            set and clear in same cycle -> set wins
//   3 TICK   R    free-running 8-bit counter, +1 every clock, wraps FF->00
//  Writes to KEY/TICK ignored. I/O reads never touch SRAM strobes (sram_oe_n stays 1).
//  Reset mid-access: async; strobes return to inactive immediately, no SRAM write completes, FSM to S_REQ.
//  CPU must hold address/we/out stable until the cycle after hold=1; changes earlier are ignored (latched in S_REQ).
// TESTING
//  1 Reset: assert reset_n=0 mid-stream -> in=00, hold=0, led=00, sram_we_n=1, sram_oe_n=1 same cycle.
//  2 SRAM read, WAIT_STATES=2, addr 1234, sram_d_i=5A -> hold 0,0,0,1; in=5A in hold=1 cycle; sram_addr=1234.
//  3 SRAM write addr 7FFF data C3 -> sram_we_n low 3 cycles, high in hold=1 cycle; d_o=C3, d_oe=1 throughout.
//  4 I/O write BF00<=A5 then read BF00 -> each access 2 cycles; led=A5 after write edge; in=A5 on read.
//  5 key[2] 0->1, read BF02 -> 04; write BF02<=04 -> reads 00; write-1 same cycle as new edge -> stays 04.
//  6 Reset pulse during S_WAIT of write -> sram_we_n=1 immediately; next access after release starts at S_REQ.

Source files
------------

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: 6502 bus slave that serves each CPU access from an async SRAM or a 4-register I/O page.
// One access per pass, no pipelining; SRAM accesses are stretched by WAIT_STATES cycles with hold low.
//   state  | meaning
//   S_REQ  | access on the bus: decode, latch, start SRAM strobes
//   S_WAIT | SRAM wait cycles, cnt counts down to terminal 0
//   S_DONE | hold=1 for one cycle, CPU advances
module cpu_bus_responder #(
  parameter int          ADDR_W      = 15,
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] IO_BASE     = 16'hBF00
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [15:0]       address,
  input  logic [7:0]        out,
  input  logic              we,
  output logic [7:0]        in,
  output logic              hold,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_d_o,
  output logic              sram_d_oe,
  input  logic [7:0]        sram_d_i,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  input  logic [3:0]        key,
  output logic [7:0]        led
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              we_q;
  logic              io_q;

  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        cur_data;
  logic              cur_we;
  logic              cur_io;

  logic              io_hit;
  logic              capture;
  logic              io_wr;
  logic              sram_rd;
  logic              sram_wr;
  logic [1:0]        io_off;
  logic [7:0]        io_rdata;

  logic [3:0]        key_meta;
  logic [3:0]        key_sync;
  logic [3:0]        key_prev;
  logic [3:0]        edge_q;
  logic [3:0]        edge_set;
  logic [3:0]        edge_clr;
  logic [7:0]        tick;

  assign io_hit = (address[15:2] == IO_BASE[15:2]);

  // During S_REQ the live bus is the access; afterwards the latched copy is used,
  // so CPU changes after the request cycle cannot disturb an access in flight.
  always_comb begin
    cur_addr = addr_q;
    cur_data = data_q;
    cur_we   = we_q;
    cur_io   = io_q;
    if (state == S_REQ) begin
      cur_addr = address[ADDR_W-1:0];
      cur_data = out;
      cur_we   = we;
      cur_io   = io_hit;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_REQ;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_REQ: begin
        if (io_hit || (WAIT_STATES == 0)) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_WAIT;
          cnt_nxt   = 4'(WAIT_STATES - 1);
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_DONE:  state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      data_q <= 8'd0;
      we_q   <= 1'b0;
      io_q   <= 1'b0;
    end else if (state == S_REQ) begin
      addr_q <= address[ADDR_W-1:0];
      data_q <= out;
      we_q   <= we;
      io_q   <= io_hit;
    end
  end

  assign hold    = (state == S_DONE);
  assign capture = (state_nxt == S_DONE);

  // Strobes are gated by reset_n directly so an async reset releases the SRAM at once.
  assign sram_rd   = reset_n & ~cur_io & ~cur_we;
  assign sram_wr   = reset_n & ~cur_io & cur_we;
  assign sram_addr = reset_n ? cur_addr : '0;
  assign sram_d_o  = cur_data;
  assign sram_d_oe = sram_wr;
  assign sram_oe_n = ~sram_rd;
  assign sram_we_n = ~(sram_wr & (state != S_DONE));

  assign io_off = cur_addr[1:0];
  assign io_wr  = capture & cur_io & cur_we;

  always_comb begin
    io_rdata = 8'd0;
    case (io_off)
      2'd0:    io_rdata = led;
      2'd1:    io_rdata = {4'b0000, key_sync};
      2'd2:    io_rdata = {4'b0000, edge_q};
      default: io_rdata = tick;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in <= 8'd0;
    end else if (capture && !cur_we) begin
      in <= cur_io ? io_rdata : sram_d_i;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      led <= 8'd0;
    end else if (io_wr && (io_off == 2'd0)) begin
      led <= cur_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_meta <= 4'd0;
      key_sync <= 4'd0;
      key_prev <= 4'd0;
    end else begin
      key_meta <= key;
      key_sync <= key_meta;
      key_prev <= key_sync;
    end
  end

  // A new rising edge in the same cycle as a write-1 clear keeps the bit set.
  assign edge_set = key_sync & ~key_prev;
  assign edge_clr = (io_wr && (io_off == 2'd2)) ? cur_data[3:0] : 4'd0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      edge_q <= 4'd0;
    end else begin
      edge_q <= (edge_q & ~edge_clr) | edge_set;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick <= 8'd0;
    end else begin
      tick <= tick + 8'd1;
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Scoreboard bench for cpu_bus_responder: the driver pushes expected responses from a
// reference model (SRAM array, LED/KEY/EDGE values, cycle count); a negedge monitor checks them on hold.
module tb_cpu_bus_responder;
  localparam int WS = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [7:0]  out = 8'h00;
  logic        we = 1'b0;
  logic [7:0]  in;
  logic        hold;
  logic [14:0] sram_addr;
  logic [7:0]  sram_d_o;
  logic        sram_d_oe;
  logic [7:0]  sram_d_i;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [3:0]  key = 4'h0;
  logic [7:0]  led;

  cpu_bus_responder #(.ADDR_W(15), .WAIT_STATES(WS), .IO_BASE(16'hBF00)) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .out(out), .we(we),
    .in(in), .hold(hold), .sram_addr(sram_addr), .sram_d_o(sram_d_o),
    .sram_d_oe(sram_d_oe), .sram_d_i(sram_d_i), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .key(key), .led(led)
  );

  always #5 clock = ~clock;

  // board SRAM: async read, write commits on the rising edge of we_n
  logic [7:0] mem [0:32767];
  assign sram_d_i = mem[sram_addr];
  always @(posedge sram_we_n) if (reset_n && sram_d_oe) mem[sram_addr] <= sram_d_o;

  int unsigned cyc;
  always @(posedge clock or negedge reset_n)
    if (!reset_n) cyc <= 0; else cyc <= cyc + 1;

  logic [7:0] ref_mem [0:32767];
  logic [7:0] ref_led = 8'h00;
  logic [3:0] ref_key = 4'h0;
  logic [3:0] ref_edge = 4'h0;

  typedef struct {
    bit          rd;
    bit          sram;
    bit          chk_led;
    logic [7:0]  data;
    logic [7:0]  wdata;
    logic [7:0]  led_v;
    logic [14:0] saddr;
    int unsigned lat;
    int unsigned t0;
  } exp_t;

  exp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  int we_lo = 0, oe_lo = 0, doe_hi = 0;

  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset_n) begin
      we_lo = 0; oe_lo = 0; doe_hi = 0;
    end else begin
      if (!sram_we_n) we_lo++;
      if (!sram_oe_n) oe_lo++;
      if (sram_d_oe)  doe_hi++;
      check("oe_we_overlap", (!sram_oe_n && !sram_we_n), 0);
      if (hold) begin
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_hold: got hold=1 expected no access pending (t=%0t)", $time);
        end else begin
          e = sbq.pop_front();
          check("latency", cyc - e.t0 + 1, e.lat);
          if (e.rd) check("read_data", in, e.data);
          check("we_low_cycles", we_lo, (e.sram && !e.rd) ? 1 + WS : 0);
          check("oe_low_cycles", oe_lo, (e.sram && e.rd) ? 2 + WS : 0);
          check("d_oe_cycles", doe_hi, (e.sram && !e.rd) ? 2 + WS : 0);
          if (e.sram) check("sram_addr", sram_addr, e.saddr);
          if (e.sram && !e.rd) check("sram_d_o", sram_d_o, e.wdata);
          if (e.chk_led) check("led", led, e.led_v);
        end
        we_lo = 0; oe_lo = 0; doe_hi = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after hold, with the next access due.
  task automatic access(input logic [15:0] a, input bit w, input logic [7:0] d,
                        input logic [3:0] coincide = 4'h0);
    exp_t e;
    bit io, seen;
    io = (a >= 16'hBF00) && (a <= 16'hBF03);
    e.rd = !w; e.sram = !io; e.chk_led = 0;
    e.data = 8'h00; e.wdata = d; e.led_v = 8'h00;
    e.saddr = 15'(a % 32768);
    e.lat = io ? 2 : 2 + WS;
    e.t0 = cyc;
    if (!io) begin
      if (w) ref_mem[e.saddr] = d;
      else   e.data = ref_mem[e.saddr];
    end else begin
      case (a[1:0])
        2'd0: if (w) begin ref_led = d; e.chk_led = 1; e.led_v = d; end
              else e.data = ref_led;
        2'd1: if (!w) e.data = {4'h0, ref_key};
        2'd2: if (w) ref_edge = (ref_edge & ~d[3:0]) | coincide;
              else e.data = {4'h0, ref_edge};
        default: if (!w) e.data = cyc[7:0];
      endcase
    end
    sbq.push_back(e);
    address = a; we = w; out = d;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (hold) begin seen = 1; break; end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL hold_timeout: got no hold within 40 cycles expected hold for addr %h", a);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "hold never asserted");
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_key(input logic [3:0] k);
    key = k;
    ref_edge = ref_edge | (k & ~ref_key);
    ref_key = k;
  endtask

  task automatic settle();
    access(16'h0001, 0, 8'h00);
    access(16'h0002, 0, 8'h00);
  endtask

  task automatic check_reset_values();
    check("rst_in", in, 8'h00);
    check("rst_hold", hold, 1'b0);
    check("rst_led", led, 8'h00);
    check("rst_we_n", sram_we_n, 1'b1);
    check("rst_oe_n", sram_oe_n, 1'b1);
    check("rst_d_oe", sram_d_oe, 1'b0);
    check("rst_sram_addr", sram_addr, 15'h0000);
  endtask

  logic [15:0] pool [8];

  initial begin
    for (int i = 0; i < 32768; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[16'h1234] = 8'h5A;
    ref_mem[16'h1234] = 8'h5A;
    pool = '{16'h0000, 16'h0001, 16'h1234, 16'h7FFF, 16'h8000, 16'h9234, 16'hFFFF, 16'hBF04};

    #1;
    check_reset_values();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    access(16'h1234, 0, 8'h00);
    access(16'h7FFF, 1, 8'hC3);
    access(16'h7FFF, 0, 8'h00);
    access(16'hBF00, 1, 8'hA5);
    access(16'hBF00, 0, 8'h00);

    set_key(4'h4);
    settle();
    access(16'hBF02, 0, 8'h00);
    access(16'hBF01, 0, 8'h00);
    access(16'hBF02, 1, 8'h04);
    access(16'hBF02, 0, 8'h00);
    set_key(4'h0);
    settle();
    set_key(4'h4);
    access(16'hBF00, 0, 8'h00);
    access(16'hBF02, 1, 8'h04, 4'h4);
    access(16'hBF02, 0, 8'h00);

    access(16'hBF01, 1, 8'hFF);
    access(16'hBF03, 1, 8'h00);
    access(16'hBF03, 0, 8'h00);
    access(16'hBF00, 0, 8'h00);
    access(16'hBF02, 0, 8'h00);

    // abort an SRAM write in S_WAIT with an async reset
    set_key(4'h0);
    settle();
    address = 16'h0100; we = 1'b1; out = 8'hEE;
    @(posedge clock);
    #3;
    check("abort_we_active", sram_we_n, 1'b0);
    reset_n = 1'b0;
    #1;
    check_reset_values();
    ref_led = 8'h00;
    ref_edge = 4'h0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    access(16'h0100, 0, 8'h00);
    access(16'hBF00, 0, 8'h00);
    access(16'hBF03, 0, 8'h00);

    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 35)      access(pool[$urandom_range(0, 7)], 0, 8'h00);
      else if (r < 65) access(pool[$urandom_range(0, 7)], 1, 8'($urandom));
      else if (r < 95) access(16'hBF00 + 16'($urandom_range(0, 3)), 1'($urandom), 8'($urandom));
      else begin
        set_key(4'($urandom));
        settle();
      end
    end

    check("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
